// File: rtl/rd53_bit_deserializer.sv
// rd53_bit_deserializer
// Collects serial operand bits x0..x4 into a 5-bit vector for the rd53 NOR
// evaluation stage. Valid/ready handshakes are used on both sides. A single
// output holding register lets the next frame be collected while the
// current vector waits for downstream.
//
// Optional feature: define RD53_POPCOUNT_EN to add the out_cnt port, which
// carries the number of ones in out_x and is registered alongside it.
module rd53_bit_deserializer (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_sof,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_x,
`ifdef RD53_POPCOUNT_EN
    output logic [2:0] out_cnt,
`endif
    output logic [7:0] frm_cnt,
    output logic       sof_err
);

    // EMPTY: the holding register has no vector. FULL: out_x is being offered.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } hold_state_t;

    localparam logic [2:0] LAST_IDX = 3'd4;

    logic [2:0]  idx;          // position of the next bit within the frame
    logic [4:0]  collect;      // partially assembled frame, collect[i] = xi
    logic [4:0]  frame_x;      // complete frame formed on the fifth bit
    hold_state_t state;
    hold_state_t state_next;
    logic        in_xfer;
    logic        out_xfer;
    logic        frame_done;
    logic        sof_abort;

`ifdef RD53_POPCOUNT_EN
    // Number of ones in a 5-bit vector (0..5).
    function automatic logic [2:0] popcount5(input logic [4:0] v);
        logic [2:0] sum;
        sum = 3'd0;
        for (int i = 0; i < 5; i++) begin
            sum = sum + {2'b00, v[i]};
        end
        return sum;
    endfunction
`endif

    // Input back-pressure: stall only the fifth bit, and only while the
    // held vector cannot leave in the same cycle. Closed during reset.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        in_ready = 1'b1;
        if (rst) begin
            in_ready = 1'b0;
        end else if (state == FULL && idx == LAST_IDX && !out_ready) begin
            in_ready = 1'b0;
        end
    end

    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = out_valid && out_ready;
    // A start-of-frame marker always restarts the frame, even on the fifth slot.
    assign frame_done = in_xfer && !in_sof && (idx == LAST_IDX);
    assign sof_abort  = in_xfer && in_sof && (idx != 3'd0);
    assign frame_x    = {in_bit, collect[3:0]};

    // Bit index and collect register: write the bit at its slot and advance.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            idx     <= 3'd0;
            collect <= 5'd0;
        end else if (in_xfer) begin
            if (in_sof) begin
                // Restart: the partial bits are dropped and this bit becomes x0.
                collect <= {4'b0000, in_bit};
                idx     <= 3'd1;
            end else if (idx == LAST_IDX) begin
                idx <= 3'd0;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (idx == 3'(i)) begin
                        collect[i] <= in_bit;
                    end
                end
                idx <= idx + 3'd1;
            end
        end
    end

    // Holding-register FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Holding-register FSM: next state. A completion in the same cycle as an
    // out-transfer reloads the register, so the vector follows without a bubble.
    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY: begin
                if (frame_done) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (out_xfer && !frame_done) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // Holding-register FSM: outputs.
    always_comb begin
        out_valid = (state == FULL);
    end

    // Output holding register: load the completed frame. out_x stays stable
    // while it is held, because a frame can only complete when the slot is
    // free or is emptied in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: the vector registers are cleared on reset because downstream may look at out_x while out_valid=0.
        if (rst) begin
            out_x <= 5'd0;
        end else if (frame_done) begin
            out_x <= frame_x;
        end
    end

`ifdef RD53_POPCOUNT_EN
    // Popcount register, loaded in the same cycle as out_x.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt <= 3'd0;
        end else if (frame_done) begin
            out_cnt <= popcount5(frame_x);
        end
    end
`endif

    // Handoff counter: counts vectors accepted downstream and wraps at 8 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            frm_cnt <= 8'd0;
        end else if (out_xfer) begin
            frm_cnt <= frm_cnt + 8'd1;
        end
    end

    // Abort flag: one-cycle pulse after a start marker cuts a partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sof_err <= 1'b0;
        end else begin
            sof_err <= sof_abort;
        end
    end

endmodule

// File: doc/rd53_bit_deserializer.md
RD53_BIT_DESERIALIZER -- requirements
Module: rd53_bit_deserializer

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port: in_valid  input  1  upstream bit valid.
REQ-004 SHALL have port: in_ready  output  1  block accepts a bit this cycle.
REQ-005 SHALL have port: in_bit  input  1  serial operand bit; first bit of a frame is x0, last is x4.
REQ-006 SHALL have port: in_sof  input  1  start-of-frame marker qualifying in_bit.
REQ-007 SHALL have port: out_valid  output  1  assembled vector available to the rd53 NOR evaluation stage.
REQ-008 SHALL have port: out_ready  input  1  downstream stage accepts the vector.
REQ-009 SHALL have port: out_x  output  5  assembled operand vector; out_x[i] = xi.
REQ-010 SHALL have port: out_cnt  output  3  popcount of out_x, present only when the macro in REQ-030 is defined.
REQ-011 SHALL have port: frm_cnt  output  8  number of vectors handed off downstream, wrapping.
REQ-012 SHALL have port: sof_err  output  1  one-cycle pulse when in_sof aborts a partial frame.

Function
REQ-013 SHALL accept a bit ("in-transfer") exactly on cycles with in_valid=1 and in_ready=1; "out-transfer" exactly on cycles with out_valid=1 and out_ready=1.
REQ-014 SHALL keep a 3-bit bit index (0..4) and a 5-bit collect register; an in-transfer writes in_bit to collect[index] and increments index.
REQ-015 SHALL, on an in-transfer at index 4, move the completed 5-bit frame into the output holding register, set out_valid=1 the next cycle, and return index to 0.
REQ-016 SHALL register out_x (latency: 1 cycle from the fifth in-transfer to out_valid=1); out_x, out_cnt SHALL stay stable while out_valid=1 and out_ready=0.
REQ-017 SHALL operate as a two-state FSM on the holding register: EMPTY (out_valid=0) and FULL (out_valid=1); EMPTY->FULL on frame completion, FULL->EMPTY on out-transfer without simultaneous completion, FULL->FULL when out-transfer and completion coincide (new frame loaded, no bubble).
REQ-018 SHALL keep accepting bits for indices 0..3 while FULL; in_ready SHALL be 0 only when FULL, index=4 and out_ready=0 (in_ready may depend combinationally on out_ready).
REQ-019 SHALL, on an in-transfer with in_sof=1, write in_bit to collect[0] and set index to 1, regardless of the prior index.
REQ-020 SHALL pulse sof_err for one cycle after an in-transfer with in_sof=1 while index was 1..4; partial bits are discarded, holding register unaffected.
REQ-021 SHALL treat in_sof=0 at index 0 as a normal first bit (sof is optional on frame boundaries).
REQ-022 SHALL ignore in_bit and in_sof when no in-transfer occurs.
REQ-023 SHALL increment frm_cnt by 1 per out-transfer, wrapping 255->0.
REQ-024 SHALL drive out_cnt = number of ones in out_x (0..5), registered alongside out_x.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, clear index, collect register, out_x, out_cnt, frm_cnt, out_valid and sof_err to 0.
REQ-026 SHALL drive in_ready=0 during a reset cycle and in_ready=1 on the first cycle after reset deasserts.
REQ-027 SHALL discard any partial frame and any held vector when reset is asserted mid-operation; no out-transfer counts during reset.
REQ-028 SHALL have no asynchronous reset path.

Configuration
REQ-029 SHALL compile out popcount logic by default.
REQ-030 SHALL, when macro RD53_POPCOUNT_EN is defined, include out_cnt port and its register per REQ-024; when undefined, out_cnt port and logic SHALL be absent and all other behaviour identical.

Verification
REQ-031 SHALL cover: after reset, bits 1,0,1,1,0 (x0..x4) back-to-back, out_ready=1 -> out_valid one cycle after fifth bit, out_x=5'b01101, out_cnt=3, frm_cnt=1.
REQ-032 SHALL cover: out_ready=0, two frames 11111 then 00001 streamed -> in_ready=0 with index=4 pending; raise out_ready -> out_x=5'b11111 taken, then 5'b10000 presented with no bubble, frm_cnt=2.
REQ-033 SHALL cover: bits 1,1,0 then in_sof=1 with in_bit=0, then 1,1,1,1 -> sof_err pulses once, out_x=5'b11110.
REQ-034 SHALL cover: 256 frames with out_ready=1 -> frm_cnt wraps to 0.
REQ-035 SHALL cover: rst=1 for one cycle after 3 bits and with a held vector -> out_valid=0, frm_cnt=0, next 5 bits form a fresh frame from x0.
REQ-036 SHALL cover: build without RD53_POPCOUNT_EN -> out_cnt absent, REQ-031 out_x and timing unchanged.
